// File: rtl/operand_pkg.sv
// Shared operand types for the 4-operand adder tree datapath.
// Reused by the packer, the adder_tree4_8 wrappers and their benches.
package operand_pkg;
  localparam int OPERAND_WIDTH = 8;
  localparam int NUM_OPERANDS  = 4;

  typedef logic [OPERAND_WIDTH-1:0]  operand_t;
  typedef operand_t [NUM_OPERANDS-1:0] operand_vec_t;
  typedef logic [2:0]                group_len_t;
endpackage

// File: rtl/operand_packer4_8.sv
// Stream-to-vector packer: gathers up to four operands into one zero-filled a/b/c/d bundle
// held under a valid/ready handshake; a completed group waits in the slots if the output is busy.
module operand_packer4_8
  import operand_pkg::*;
#(
  parameter int DATA_WIDTH = OPERAND_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] c,
  output logic [DATA_WIDTH-1:0] d,
  output group_len_t            group_len
);

  typedef logic [NUM_OPERANDS-1:0][DATA_WIDTH-1:0] lane_vec_t;

  lane_vec_t  slot_q, slot_d, out_q, out_d, fill;
  logic [1:0] idx_q, idx_d;
  logic       pend_q, pend_d;
  logic       vld_q, vld_d;
  group_len_t len_q, len_d;
  logic       out_free, accept, complete, xfer;

  // Ready is purely registered state plus reset: no path from in_valid or out_ready.
  assign in_ready = rst_n && !pend_q;

  always_comb begin
    out_free = !vld_q || out_ready;
    accept   = in_valid && in_ready;
    complete = accept && ((idx_q == 2'd3) || in_last);
    xfer     = out_free && (pend_q || complete);

    // The completing byte is merged here so it reaches the output the same edge it arrives.
    slot_d = slot_q;
    if (accept) slot_d[idx_q] = in_data;

    fill = '0;
    for (int i = 0; i < NUM_OPERANDS; i++)
      if (i <= int'(idx_q)) fill[i] = slot_d[i];

    idx_d  = idx_q;
    pend_d = pend_q;
    vld_d  = vld_q;
    out_d  = out_q;
    len_d  = len_q;

    if (vld_q && out_ready) vld_d = 1'b0;

    if (xfer) begin
      out_d  = fill;
      len_d  = {1'b0, idx_q} + 3'd1;
      vld_d  = 1'b1;
      idx_d  = 2'd0;
      pend_d = 1'b0;
    end else if (complete) begin
      // idx is kept: it still names the last real lane for the deferred transfer.
      pend_d = 1'b1;
    end else if (accept) begin
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= '0;
      out_q  <= '0;
      idx_q  <= 2'd0;
      pend_q <= 1'b0;
      vld_q  <= 1'b0;
      len_q  <= '0;
    end else begin
      slot_q <= slot_d;
      out_q  <= out_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      vld_q  <= vld_d;
      len_q  <= len_d;
    end
  end

  assign out_valid = vld_q;
  assign a         = out_q[0];
  assign b         = out_q[1];
  assign c         = out_q[2];
  assign d         = out_q[3];
  assign group_len = len_q;

endmodule

// File: tb/tb_operand_packer4_8.sv
// Scoreboard bench for operand_packer4_8: directed test-plan sequences followed by random
// traffic with random backpressure, checked against a queue-based group model.
module tb_operand_packer4_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_last, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_ready;
  logic [7:0] a, b, c, d;
  logic [2:0] group_len;

  logic rand_mode, or_dir, or_rand;
  assign out_ready = rand_mode ? or_rand : or_dir;

  operand_packer4_8 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .c(c), .d(d), .group_len(group_len)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][7:0] v;
    logic [2:0]      len;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] part[$];
  int         n_chk = 0;
  int         n_fail = 0;
  bit         rst_seen = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor/model: runs between edges and describes what the next edge will do.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("in_ready_in_reset", in_ready, 0);
      sb.delete();
      part.delete();
      rst_seen = 1'b1;
    end else begin
      if (rst_seen) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_group_len", group_len, 0);
        chk("rst_lanes", {d, c, b, a}, 0);
        rst_seen = 1'b0;
      end
      // Two unconsumed groups means one is stuck behind the output register.
      chk("in_ready", in_ready, (sb.size() < 2) ? 1 : 0);
      chk("out_valid", out_valid, (sb.size() != 0) ? 1 : 0);
      if (out_valid && sb.size() != 0) begin
        chk("bundle", {d, c, b, a}, sb[0].v);
        chk("group_len", group_len, sb[0].len);
        chk("tree_sum", 64'(a) + 64'(b) + 64'(c) + 64'(d),
            64'(sb[0].v[0]) + 64'(sb[0].v[1]) + 64'(sb[0].v[2]) + 64'(sb[0].v[3]));
        if (out_ready) void'(sb.pop_front());
      end
      if (in_valid && in_ready) begin
        part.push_back(in_data);
        if (part.size() == 4 || in_last) begin
          exp_t e;
          e.v = '0;
          for (int i = 0; i < part.size(); i++) e.v[i] = part[i];
          e.len = 3'(part.size());
          sb.push_back(e);
          part.delete();
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    or_rand = 1'($urandom % 2);
  end

  // All tasks start and end at posedge+1.
  task automatic send(input logic [7:0] v, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = v;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) begin
      $display("FAIL send_timeout: in_ready stuck low for byte %0d", v);
      $fatal(1, "stalled");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'hxx;
  endtask

  task automatic drain();
    int n = 0;
    while (out_valid && n < 500) begin
      n++;
      @(posedge clk);
      #1;
    end
    if (n >= 500) begin
      $display("FAIL drain_timeout: out_valid never dropped");
      $fatal(1, "stalled");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    rand_mode = 1'b0; or_dir = 1'b1; or_rand = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic group, then back-to-back groups
    send(4, 0); send(5, 0); send(11, 0); send(9, 0);
    drain();
    send(4, 0); send(5, 0); send(11, 0); send(9, 0);
    send(15, 0); send(3, 0); send(200, 0); send(7, 0);
    drain();

    // short groups
    send(15, 0); send(3, 1);
    send(42, 1);
    drain();

    // backpressure: second group gets stuck behind the first
    or_dir = 1'b0;
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    send(5, 0); send(6, 0); send(7, 0); send(8, 0);
    repeat (3) @(posedge clk);
    #1;
    or_dir = 1'b1;
    drain();

    // reset mid-group
    send(1, 0); send(2, 0);
    do_reset();
    send(10, 0); send(20, 0); send(30, 0); send(40, 0);
    drain();

    // reset while a group is pending
    or_dir = 1'b0;
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    send(5, 0); send(6, 0); send(7, 0); send(8, 1);
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    or_dir = 1'b1;
    send(10, 0); send(20, 0); send(30, 0); send(40, 0);
    drain();

    // random traffic with random backpressure
    rand_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom % 4 == 0) begin
        @(posedge clk);
        #1;
      end
      send(8'($urandom), ($urandom % 5) == 0);
    end
    rand_mode = 1'b0;
    drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
